// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes match the decode stage's MDU field.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes.
// Assumes rem < dvs, so the shifted remainder fits WIDTH+1 bits.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvs,
    input  logic             din,
    output logic [WIDTH-1:0] rem_n,
    output logic             qbit
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    assign sh    = {rem, din};
    assign diff  = sh - {1'b0, dvs};
    assign qbit  = ~diff[WIDTH];
    assign rem_n = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// One radix-2 step per cycle, then a fix-up cycle for signs.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int W2 = 2 * WIDTH;

    state_t state, state_n;

    logic [CW-1:0]    cnt;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             dvz;

    logic md_op, sgn_op, div_op;
    logic load, step, commit, wr_hi, wr_lo;

    logic [WIDTH-1:0] mag_a, mag_b;

    assign md_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_DIV)  || (op == OP_DIVU);
    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op = (op == OP_DIV)  || (op == OP_DIVU);

    assign mag_a = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn_op && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] drem;
    logic             dq;
    logic [W2-1:0]    acc_step;

    assign msum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    mdu_divstep #(
        .WIDTH(WIDTH)
    ) u_divstep (
        .rem  (acc[W2-1:WIDTH]),
        .dvs  (opnd),
        .din  (acc[WIDTH-1]),
        .rem_n(drem),
        .qbit (dq)
    );

    assign acc_step = is_div ? {drem, acc[WIDTH-2:0], dq}
                             : {msum, acc[WIDTH-1:1]};

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rmd, res_hi, res_lo;

    always_comb begin
        prod   = neg_res ? -acc : acc;
        quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd    = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
        res_hi = prod[W2-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = dvz ? a_raw : rmd;
            res_lo = dvz ? '1 : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    unique case (1'b1)
                        md_op: begin
                            load    = 1'b1;
                            state_n = S_RUN;
                        end
                        op == OP_MTHI: wr_hi = 1'b1;
                        op == OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(1)) state_n = S_FIX;
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                commit  = !flush;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dvz     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            busy <= (state_n != S_IDLE);
            done <= commit;
            if (load) begin
                cnt     <= CW'(WIDTH);
                acc     <= {{WIDTH{1'b0}}, div_op ? mag_a : mag_b};
                opnd    <= div_op ? mag_b : mag_a;
                a_raw   <= a;
                is_div  <= div_op;
                neg_res <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= sgn_op && a[WIDTH-1];
                dvz     <= (b == '0);
            end else if (step) begin
                cnt <= cnt - CW'(1);
                acc <= acc_step;
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, corner
// sequences and random ops against an arithmetic model.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .flush(flush),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {hi, lo} straight from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        int q, m;
        logic [63:0] r;
        r = '0;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                r = p;
            end
            3'd1: r = {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) r = {x, 32'hffffffff};
                else if (x == 32'h80000000 && y == 32'hffffffff)
                    r = {32'h0, 32'h80000000};
                else begin
                    q = $signed(x) / $signed(y);
                    m = $signed(x) % $signed(y);
                    r = {m, q};
                end
            end
            3'd3: begin
                if (y == 0) r = {x, 32'hffffffff};
                else r = {x % y, x / y};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit seen);
        bc   = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic watch_nodone(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic run_chk(input string tag, input logic [2:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] exp);
        int bc;
        bit seen;
        issue(o, x, y);
        wait_done(bc, seen);
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_lat"}, bc, 33);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hi"}, hi, exp[63:32]);
        chk({tag, "_lo"}, lo, exp[31:0]);
        @(negedge clk);
        chk({tag, "_done2"}, done, 0);
    endtask

    initial begin
        int bc, nd;
        bit seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vt[0] = '{3'd0, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb};
        vt[1] = '{3'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h1};
        vt[2] = '{3'd2, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd};
        vt[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        vt[4] = '{3'd2, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000};
        vt[5] = '{3'd3, 32'h1234, 32'h0, 32'h1234, 32'hffffffff};
        vt[6] = '{3'd2, 32'h1234, 32'h0, 32'h1234, 32'hffffffff};
        vt[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        vt[8] = '{3'd2, 32'd7, 32'hfffffffe, 32'd1, 32'hfffffffd};
        vt[9] = '{3'd1, 32'h10000, 32'h10000, 32'h1, 32'h0};

        rst_n = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;

        // MTHI then MTLO back to back
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'haaaa;
        @(negedge clk);
        chk("mt_done0", done, 0);
        op = 3'b101;
        a  = 32'h5555;
        @(negedge clk);
        chk("mt_done1", done, 0);
        start = 1'b0;
        chk("mthi", hi, 32'haaaa);
        chk("mtlo", lo, 32'h5555);
        @(negedge clk);
        chk("mt_done2", done, 0);

        // async reset in the middle of a DIVU
        issue(3'd3, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_nodone(40, nd);
        chk("arst_nodone", nd, 0);
        chk("arst_hi2", hi, 0);

        for (int i = 0; i < 10; i++)
            run_chk($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                    {vt[i].hi, vt[i].lo});

        // start while busy is ignored
        issue(3'd2, 32'hffffff9c, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen);
        chk("hs_done", seen, 1);
        chk("hs_lat", bc, 28);
        chk("hs_hi", hi, 32'hfffffffe);
        chk("hs_lo", lo, 32'hfffffff2);

        // flush mid-RUN keeps HI/LO
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h1111;
        @(negedge clk);
        op = 3'b101;
        a  = 32'h2222;
        @(negedge clk);
        start = 1'b0;
        issue(3'd0, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy", busy, 0);
        watch_nodone(40, nd);
        chk("fl_nodone", nd, 0);
        chk("fl_hi", hi, 32'h1111);
        chk("fl_lo", lo, 32'h2222);

        // flush wins over a same-cycle start in IDLE
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b100;
        a     = 32'hdead;
        @(negedge clk);
        op = 3'd0;
        a  = 32'd3;
        b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("fs_busy", busy, 0);
        chk("fs_hi", hi, 32'h1111);
        watch_nodone(5, nd);
        chk("fs_nodone", nd, 0);
        chk("fs_busy2", busy, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hffffffff;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_chk($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
